// File: rtl/div_unit.sv
// div_unit: iterative 32-bit integer divider for DIV/DIVU.
// Uses one radix-2 restoring step per cycle on operand magnitudes.
// Sign correction is applied when the last step retires.
// hi returns the remainder and lo returns the quotient.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for start; operands are captured on acceptance
// S_CALC | 32 restoring steps, counter 0..31
// S_DONE | signed result staged; ready/hi/lo commit on the exit edge

module div_unit (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic        sign,
   input  logic [31:0] op1,
   input  logic [31:0] op2,
   input  logic        cancel,
   output logic        busy,
   output logic        ready,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [5:0]  cnt;
   logic [31:0] dvsr;
   logic [63:0] prem;
   logic        q_neg;
   logic        r_neg;
   logic [31:0] res_q;
   logic [31:0] res_r;

   logic        accept;
   logic        last_step;
   logic        finish;
   logic        div_zero;
   logic [31:0] op1_mag;
   logic [31:0] op2_mag;
   logic [63:0] prem_sh;
   logic [32:0] diff;
   logic [63:0] prem_step;
   logic [31:0] q_fin;
   logic [31:0] r_fin;

   // handshake qualifiers; cancel always beats start and completion
   always_comb begin
      accept    = (state == S_IDLE) && start && !cancel;
      last_step = (state == S_CALC) && (cnt == 6'd31);
      finish    = (state == S_DONE) && !cancel;
      div_zero  = (op2 == 32'd0);
   end

   // operand magnitudes: only negative values in signed mode are flipped
   always_comb begin
      op1_mag = (sign && op1[31]) ? (~op1 + 32'd1) : op1;
      op2_mag = (sign && op2[31]) ? (~op2 + 32'd1) : op2;
   end

   // one restoring step: shift, trial-subtract on 33 bits, keep if non-negative
   always_comb begin
      prem_sh   = {prem[62:0], 1'b0};
      diff      = {1'b0, prem_sh[63:32]} - {1'b0, dvsr};
      prem_step = prem_sh;
      if (!diff[32]) begin
         prem_step = {diff[31:0], prem_sh[31:1], 1'b1};
      end
   end

   // sign fix-up of the final step (most-negative quotient wraps to itself)
   always_comb begin
      q_fin = q_neg ? (~prem_step[31:0] + 32'd1) : prem_step[31:0];
      r_fin = r_neg ? (~prem_step[63:32] + 32'd1) : prem_step[63:32];
   end

   // state register
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_nxt = div_zero ? S_DONE : S_CALC;
            end
         end
         S_CALC: begin
            if (cancel) begin
               state_nxt = S_IDLE;
            end else if (last_step) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // FSM outputs
   always_comb begin
      busy = (state != S_IDLE);
   end

   // datapath: operand capture, iteration and staged result
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt   <= 6'd0;
         dvsr  <= 32'd0;
         prem  <= 64'd0;
         q_neg <= 1'b0;
         r_neg <= 1'b0;
         res_q <= 32'd0;
         res_r <= 32'd0;
      end else if (accept) begin
         cnt   <= 6'd0;
         dvsr  <= op2_mag;
         prem  <= {32'd0, op1_mag};
         q_neg <= sign & (op1[31] ^ op2[31]);
         r_neg <= sign & op1[31];
         if (div_zero) begin
            res_q <= 32'hFFFF_FFFF;
            res_r <= op1;
         end
      end else if ((state == S_CALC) && !cancel) begin
         prem <= prem_step;
         cnt  <= cnt + 6'd1;
         if (last_step) begin
            res_q <= q_fin;
            res_r <= r_fin;
         end
      end
   end

   // result commit: ready pulses and hi/lo load only on an uncancelled exit from DONE
   always_ff @(posedge clk) begin
      if (!resetn) begin
         ready <= 1'b0;
         hi    <= 32'd0;
         lo    <= 32'd0;
      end else begin
         ready <= finish;
         if (finish) begin
            hi <= res_r;
            lo <= res_q;
         end
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit with a 64-bit arithmetic reference.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic        sign = 1'b0;
   logic        cancel = 1'b0;
   logic [31:0] op1 = 32'd0;
   logic [31:0] op2 = 32'd0;
   logic        busy;
   logic        ready;
   logic [31:0] hi;
   logic [31:0] lo;

   div_unit dut (
      .clk    (clk),
      .resetn (resetn),
      .start  (start),
      .sign   (sign),
      .op1    (op1),
      .op2    (op2),
      .cancel (cancel),
      .busy   (busy),
      .ready  (ready),
      .hi     (hi),
      .lo     (lo)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      int          when;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_q = 32'd0;
   logic [31:0] last_r = 32'd0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // reference: plain 64-bit arithmetic, C-style truncation toward zero
   function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r);
      longint sa;
      longint sb_;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (s) begin
         sa  = longint'($signed(a));
         sb_ = longint'($signed(b));
         q   = 32'(sa / sb_);
         r   = 32'(sa % sb_);
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   // monitor: every ready pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      exp_t e;
      if (resetn && ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready: got ready=1 expected no pending op (cycle %0d)", cyc);
         end else begin
            e = sb.pop_front();
            check("lo", {32'd0, lo}, {32'd0, e.q});
            check("hi", {32'd0, hi}, {32'd0, e.r});
            check("ready_cycle", 64'(cyc), 64'(e.when));
            last_q = e.q;
            last_r = e.r;
         end
      end
   end

   task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b, input bit track);
      logic [31:0] q;
      logic [31:0] r;
      sign  = s;
      op1   = a;
      op2   = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (track) begin
         model(s, a, b, q, r);
         sb.push_back('{q: q, r: r, when: cyc + ((b == 32'd0) ? 1 : 33)});
      end
      check("busy_after_start", {63'd0, busy}, 64'd1);
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (!ready && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(name, {63'd0, ready}, 64'd1);
   endtask

   initial begin
      int bc;
      int n;

      // reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_ready", {63'd0, ready}, 64'd0);
      check("rst_hi", {32'd0, hi}, 64'd0);
      check("rst_lo", {32'd0, lo}, 64'd0);

      // first cycle out of reset: DIVU 100/7 with busy-length and pulse-width checks
      resetn = 1'b1;
      issue(1'b0, 32'd100, 32'd7, 1'b1);
      bc = 1;
      n  = 0;
      while (!ready && n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (busy) bc++;
      end
      check("divu_ready_seen", {63'd0, ready}, 64'd1);
      check("divu_busy_cycles", 64'(bc), 64'd33);
      @(posedge clk);
      #1;
      check("ready_one_cycle", {63'd0, ready}, 64'd0);

      // signed corner cases and divide by zero
      issue(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);
      wait_ready("div_m7_2");
      issue(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1);
      wait_ready("div_7_m2");
      issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      wait_ready("div_min_m1");
      issue(1'b0, 32'd5, 32'd0, 1'b1);
      wait_ready("divu_5_0");
      issue(1'b1, 32'hFFFF_FFF0, 32'd0, 1'b1);
      wait_ready("div_neg_0");

      // cancel ten cycles into CALC
      issue(1'b0, 32'd1000, 32'd3, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      cancel = 1'b1;
      @(posedge clk);
      #1;
      cancel = 1'b0;
      check("cancel_busy", {63'd0, busy}, 64'd0);
      repeat (40) @(posedge clk);
      #1;
      check("cancel_hi_hold", {32'd0, hi}, {32'd0, last_r});
      check("cancel_lo_hold", {32'd0, lo}, {32'd0, last_q});

      // cancel during DONE suppresses ready and the hi/lo update
      issue(1'b0, 32'd12345, 32'd10, 1'b0);
      repeat (32) @(posedge clk);
      #1;
      cancel = 1'b1;
      @(posedge clk);
      #1;
      cancel = 1'b0;
      check("cancel_done_busy", {63'd0, busy}, 64'd0);
      repeat (3) @(posedge clk);
      #1;
      check("cancel_done_hi", {32'd0, hi}, {32'd0, last_r});
      check("cancel_done_lo", {32'd0, lo}, {32'd0, last_q});

      // cancel and start together in IDLE: no operation starts
      sign   = 1'b0;
      op1    = 32'd9;
      op2    = 32'd0;
      start  = 1'b1;
      cancel = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      cancel = 1'b0;
      check("start_cancel_busy", {63'd0, busy}, 64'd0);
      repeat (5) @(posedge clk);
      #1;

      // start while busy is ignored
      issue(1'b0, 32'd4000, 32'd9, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      op1   = 32'd77;
      op2   = 32'd0;
      sign  = 1'b1;
      start = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      start = 1'b0;
      wait_ready("busy_ignore");

      // back-to-back: second start in the cycle after ready
      issue(1'b1, 32'hFFFF_FC18, 32'd33, 1'b1);
      wait_ready("b2b_first");
      @(posedge clk);
      #1;
      issue(1'b0, 32'hDEAD_BEEF, 32'd1234, 1'b1);
      wait_ready("b2b_second");

      // randomized operations, each issued in the ready cycle of the previous one
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a;
         logic [31:0] b;
         int sel;
         a   = $urandom;
         b   = $urandom;
         sel = $urandom_range(0, 9);
         if (sel == 0) b = 32'd0;
         if (sel == 1) b = $urandom_range(1, 15);
         if (sel == 2) a = 32'h8000_0000;
         if (sel == 3) b = 32'hFFFF_FFFF;
         issue(1'($urandom_range(0, 1)), a, b, 1'b1);
         wait_ready("rand_ready");
      end
      @(posedge clk);
      #1;

      // reset in the middle of CALC discards the operation
      issue(1'b0, 32'd555, 32'd5, 1'b1);
      repeat (15) @(posedge clk);
      #1;
      resetn = 1'b0;
      @(posedge clk);
      #1;
      sb.delete();
      last_q = 32'd0;
      last_r = 32'd0;
      check("midrst_busy", {63'd0, busy}, 64'd0);
      check("midrst_ready", {63'd0, ready}, 64'd0);
      check("midrst_hi", {32'd0, hi}, 64'd0);
      check("midrst_lo", {32'd0, lo}, 64'd0);
      resetn = 1'b1;
      issue(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1);
      wait_ready("post_rst");

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
